// File: rtl/apb_pkg.sv
// apb_pkg: shared APB3 requester state, command and response types.
package apb_pkg;
  localparam int APB_DATA_WIDTH = 32;
  localparam int APB_ADDR_WIDTH = 32;
  typedef enum logic [1:0] {APB_IDLE, APB_SETUP, APB_ACCESS} apb_state_e;
  typedef struct packed {
    logic                      write;
    logic [APB_ADDR_WIDTH-1:0] addr;
    logic [APB_DATA_WIDTH-1:0] wdata;
  } apb_cmd_t;
  typedef struct packed {
    logic [APB_DATA_WIDTH-1:0] rdata;
    logic                      slverr;
    logic                      timeout;
  } apb_rsp_t;
endpackage

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command stream to APB3 SETUP/ACCESS transfers with PREADY timeout.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  apb_state_e r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic r_pwrite, r_rsp_valid, r_rsp_slverr, r_rsp_timeout;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata, r_rsp_rdata;
  logic w_access, w_done, w_abort, w_accept;
  assign w_access  = r_state == APB_ACCESS;
  assign w_done    = w_access && pready;
  // Abort only while the slave is still stalling; a same-cycle pready wins.
  assign w_abort   = (TIMEOUT_CYCLES > 0) && w_access && !pready && r_cnt == LAST;
  assign cmd_ready = r_state == APB_IDLE || w_done;
  assign w_accept  = cmd_valid && cmd_ready;
  assign psel      = r_state != APB_IDLE;
  assign penable   = w_access;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_slverr  = r_rsp_slverr;
  assign rsp_timeout = r_rsp_timeout;
  always_comb begin
    w_next = r_state;
    case (r_state)
      APB_IDLE:   w_next = w_accept ? APB_SETUP : APB_IDLE;
      APB_SETUP:  w_next = APB_ACCESS;
      APB_ACCESS: w_next = w_done ? (cmd_valid ? APB_SETUP : APB_IDLE) : (w_abort ? APB_IDLE : APB_ACCESS);
      default:    w_next = APB_IDLE;
    endcase
  end
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state       <= APB_IDLE;
      r_cnt         <= '0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_slverr  <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_pwrite <= cmd_write;
        r_paddr  <= cmd_addr;
        r_pwdata <= cmd_write ? cmd_wdata : '0;
      end
      r_cnt         <= (w_access && !pready) ? r_cnt + 1'b1 : '0;
      r_rsp_valid   <= w_done || w_abort;
      r_rsp_rdata   <= (w_done && !r_pwrite) ? prdata : '0;
      r_rsp_slverr  <= w_abort || (w_done && pslverr);
      r_rsp_timeout <= w_abort;
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: table-driven and random APB transfers against a transfer-level outcome model.
module tb_apb_master_bridge;
  localparam int T = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic rsp_valid, rsp_slverr, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata = '0;
  logic pready = 1'b0, pslverr = 1'b0;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  apb_master_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
    .pclk(clk), .preset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prd;
    int          waits;
    logic        err;
  } xfer_t;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  // Outcome model: the slave answers after x.waits stalls; more stalls than the timeout allows is an abort.
  task automatic xfer(input xfer_t x);
    bit to;
    logic [31:0] e_rd, e_pw;
    to   = x.waits >= T;
    e_rd = (to || x.wr) ? 32'h0 : x.prd;
    e_pw = x.wr ? x.wdata : 32'h0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = x.wr; cmd_addr = x.addr; cmd_wdata = x.wdata; pready = 1'b0;
    #1 chk("cmd_ready_idle", {31'h0, cmd_ready}, 32'h1);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = $urandom_range(0, 1);
    pready = $urandom_range(0, 1); pslverr = $urandom_range(0, 1); prdata = $urandom;
    #1 chk("setup_sel_en", {30'h0, psel, penable}, 32'h2);
    chk("setup_paddr", paddr, x.addr);
    chk("setup_pwdata", pwdata, e_pw);
    chk("setup_pwrite", {31'h0, pwrite}, {31'h0, x.wr});
    for (int k = 0; k < T; k++) begin
      @(negedge clk);
      pready = (k == x.waits);
      pslverr = pready ? x.err : 1'($urandom_range(0, 1));
      prdata = pready ? x.prd : $urandom;
      #1 chk("access_sel_en", {29'h0, psel, penable, rsp_valid}, 32'h6);
      chk("access_paddr", paddr, x.addr);
      chk("access_pwdata", pwdata, e_pw);
      if (pready) break;
    end
    @(negedge clk);
    pready = 1'b0;
    #1 chk("rsp_valid_sel", {30'h0, rsp_valid, psel}, 32'h2);
    chk("rsp_rdata", rsp_rdata, e_rd);
    chk("rsp_flags", {30'h0, rsp_slverr, rsp_timeout}, {30'h0, to | x.err, to});
    @(negedge clk);
    #1 chk("rsp_pulse", {31'h0, rsp_valid}, 32'h0);
  endtask
  xfer_t tbl[7];
  xfer_t rx;
  bit e_ps[8], e_pe[8], e_rv[8];
  logic [31:0] e_pa[8];
  int n_rsp;
  initial begin
    tbl[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1'b0};
    tbl[1] = '{1'b0, 32'h20, 32'h0, 32'h12345678, 3, 1'b0};
    tbl[2] = '{1'b0, 32'hFC, 32'h0, 32'hA5A5A5A5, 0, 1'b1};
    tbl[3] = '{1'b0, 32'h30, 32'h0, 32'h55AA55AA, 40, 1'b0};
    tbl[4] = '{1'b1, 32'h44, 32'hCAFEF00D, 32'h0, 2, 1'b1};
    tbl[5] = '{1'b0, 32'h48, 32'h0, 32'h0BADBEEF, T - 1, 1'b0};
    tbl[6] = '{1'b1, 32'h4C, 32'h11112222, 32'h0, T, 1'b0};
    repeat (3) @(negedge clk);
    #1 chk("reset_apb", {29'h0, psel, penable, pwrite}, 32'h0);
    chk("reset_paddr", paddr, 32'h0);
    chk("reset_pwdata", pwdata, 32'h0);
    chk("reset_rsp", {29'h0, rsp_valid, rsp_slverr, rsp_timeout}, 32'h0);
    chk("reset_rdata", rsp_rdata, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) xfer(tbl[i]);
    // Back-to-back writes with cmd_valid held: SETUP follows each ACCESS directly.
    e_ps = '{1, 1, 1, 1, 1, 1, 0, 0};
    e_pe = '{0, 1, 0, 1, 0, 1, 0, 0};
    e_rv = '{0, 0, 1, 0, 1, 0, 1, 0};
    e_pa = '{32'h0, 32'h0, 32'h4, 32'h4, 32'h8, 32'h8, 32'h8, 32'h8};
    n_rsp = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0; cmd_wdata = 32'hA0; pready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) begin cmd_addr = 32'h4; cmd_wdata = 32'hA4; end
      if (c == 2) begin cmd_addr = 32'h8; cmd_wdata = 32'hA8; end
      if (c == 4) cmd_valid = 1'b0;
      #1 chk("b2b_sel_en_rv", {29'h0, psel, penable, rsp_valid}, {29'h0, e_ps[c], e_pe[c], e_rv[c]});
      chk("b2b_paddr", paddr, e_pa[c]);
      n_rsp += int'(rsp_valid);
    end
    chk("b2b_rsp_count", n_rsp, 32'd3);
    pready = 1'b0;
    // Reset during an ACCESS wait state.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    #1 chk("pre_rst_access", {30'h0, psel, penable}, 32'h3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_mid_apb", {29'h0, psel, penable, rsp_valid}, 32'h0);
    chk("rst_mid_paddr", paddr, 32'h0);
    @(negedge clk);
    #1 chk("rst_mid_no_rsp", {31'h0, rsp_valid}, 32'h0);
    xfer('{1'b1, 32'h50, 32'h13572468, 32'h0, 1, 1'b0});
    for (int i = 0; i < 30; i++) begin
      rx.wr = 1'($urandom_range(0, 1));
      rx.addr = $urandom & 32'hFFFF_FFFC;
      rx.wdata = $urandom;
      rx.prd = $urandom;
      rx.waits = ($urandom_range(0, 9) == 0) ? $urandom_range(T, T + 4) : $urandom_range(0, 5);
      rx.err = ($urandom_range(0, 3) == 0);
      xfer(rx);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
